mem_handshake_responder: RTL and testbench
==========================================

Name: mem_handshake_responder

Overview:
- Memory-side responder for the CPU bus handshake: receives R/W strobes from the CPU clocking control and answers with Wait and Done.
- Holds a synchronous word RAM.
- Inserts a programmable number of wait states per access, then completes with a single-cycle Done.
- Sits between the CPU memory-interface registers (address/data) and the RAM array; serves as both the bench memory model and the synthesizable memory.

Parameters:
- ADDR_W, 8, address width in words.
- DATA_W, 32, data word width.
- DEPTH, 200, number of implemented words; valid addresses are 0..DEPTH-1, with DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2, number of cycles Wait is held high per access (0..15).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- R  input  1  read request from CPU; held high until Done is seen.
- W  input  1  write request from CPU; held high until Done is seen.
- addr  input  ADDR_W  word address; valid while R or W is high.
- wdata  input  DATA_W  write data; valid while W is high.
- rdata  output  DATA_W  read data; registered, valid from the Done cycle onward.
- Wait  output  1  access in progress; registered.
- Done  output  1  access complete, single-cycle pulse; registered.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, Wait=0, Done=0, rdata=0, wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - R or W sampled high: capture addr, wdata and the op (W has priority when R and W are both high: access is a write, rdata unchanged).
  - Next state is WAIT, or DONE if WAIT_CYCLES=0.
  - Load counter with WAIT_CYCLES-1.
- WAIT:
  - Wait=1.
  - Counter decrements each cycle; at 0, next state is DONE.
  - Wait is high for exactly WAIT_CYCLES consecutive cycles, starting the cycle after the request is sampled.
- Entering DONE (same clock edge):
  - Write op: mem[addr_q] <= wdata_q.
  - Read op: rdata <= mem[addr_q].
- DONE: Wait=0, Done=1 for exactly one cycle; next state HOLD.
- HOLD:
  - Wait=0, Done=0.
  - Stay in HOLD until R=0 and W=0 are sampled together, then go to IDLE.
  - Prevents a held strobe from being taken as a second request.
- Latency: request sampled at edge N -> Done high in cycle N+WAIT_CYCLES+1.
- rdata holds its last read value through writes and idle periods.
- R/W dropping early (in WAIT): the access still completes using the captured values; Done still pulses; HOLD then exits on the next cycle.
- addr/wdata changes after capture are ignored.
- Reset mid-access: abort immediately. No RAM write occurs unless the DONE-entry edge has already happened.
- A request still high when reset is released is taken as a new request in IDLE.
- Out-of-range address (addr >= DEPTH) without the optional feature: the address wraps modulo DEPTH.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - Access with captured addr >= DEPTH: no RAM write, rdata unchanged, err=1 coincident with the Done pulse (single cycle).
  - Handshake timing is unchanged.
- Not defined: no err port; out-of-range addresses wrap modulo DEPTH.

Test Plan:
- Write then read, WAIT_CYCLES=2: W=1, addr=5, wdata=32'hDEADBEEF -> Wait high exactly 2 cycles, Done high in cycle 3. Drop W, then R=1, addr=5 -> rdata=32'hDEADBEEF when Done=1.
- Held strobe: keep R=1 for 6 cycles after Done -> no second Wait/Done. Drop R, raise again -> new access with a full 2-cycle Wait.
- R and W both high, addr=7, wdata=32'h1234 -> write performed, rdata keeps its previous value. A later read of addr 7 returns 32'h1234.
- Reset mid-WAIT: W=1, addr=9, wdata=32'hAAAA; assert rst=0 during the first Wait cycle -> Wait/Done=0 immediately; a later read of addr 9 returns the prior contents, not 32'hAAAA.
- WAIT_CYCLES=0: R=1 -> Wait never high, Done high the cycle after the request is sampled.
- MEM_ADDR_CHECK_EN defined: W=1, addr=210, wdata=32'hFFFF -> err=1 and Done=1 in the same cycle. A read of addr 10 is unchanged (no wrap write) and returns with err=0.

Source files
------------

// File: rtl/mem_handshake_responder.sv
// Memory-side responder for the CPU R/W strobe handshake: synchronous word RAM,
// WAIT_CYCLES wait states per access, then a single-cycle Done. Optional MEM_ADDR_CHECK_EN adds err.
module mem_handshake_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              R,
  input  logic              W,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              Wait,
  output logic              Done
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wait_q, wait_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                ok_q, ok_d;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_ok;
  logic                enter_done;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_ADDR_CHECK_EN
  logic err_q, err_d;

  // Out-of-range accesses keep their raw address and are suppressed at DONE entry.
  always_comb begin
    cap_addr = addr;
    cap_ok   = (32'(addr) < 32'(DEPTH));
  end
`else
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % 32'(DEPTH));
  endfunction

  always_comb begin
    cap_addr = wrap_addr(addr);
    cap_ok   = 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ok_d    = ok_q;
    unique case (state_q)
      S_IDLE: begin
        if (R || W) begin
          addr_d  = cap_addr;
          wdata_d = wdata;
          we_d    = W;
          ok_d    = cap_ok;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        if (!R && !W) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The _d access fields already hold the live inputs when DONE is entered straight from IDLE.
    enter_done = (state_d == S_DONE);
    wait_d     = (state_d == S_WAIT);
    done_d     = enter_done;
    mem_we     = rst && enter_done && we_d && ok_d;

    rdata_d = rdata_q;
    if (enter_done && !we_d && ok_d) rdata_d = mem[addr_d];
  end

`ifdef MEM_ADDR_CHECK_EN
  always_comb err_d = enter_done && !ok_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef MEM_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    we_q    <= we_d;
    ok_q    <= ok_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_d] <= wdata_d;
  end

  assign rdata = rdata_q;
  assign Wait  = wait_q;
  assign Done  = done_q;
`ifdef MEM_ADDR_CHECK_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Scoreboard bench for mem_handshake_responder: a driver issues handshakes and queues the
// expected response from an array memory model; a negedge monitor checks every Done.
module tb_mem_handshake_responder;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 200;
  localparam int WC  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          R     = 1'b0;
  logic          W     = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          Wait;
  logic          Done;
`ifdef MEM_ADDR_CHECK_EN
  logic          err;
`endif

  mem_handshake_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst_n), .R(R), .W(W), .addr(addr), .wdata(wdata),
    .rdata(rdata), .Wait(Wait), .Done(Done)
`ifdef MEM_ADDR_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rd;
    bit            er;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] last_rd = '0;
  int            tests = 0;
  int            fails = 0;
  int            wait_seen = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every Done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_seen = 0;
    end else begin
      if (Wait) wait_seen++;
      if (Done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got Done=1 expected no pending access (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("rdata", rdata, mon_e.rd);
          chk("done_cycle", cyc, mon_e.due);
          chk("wait_len", wait_seen, WC);
`ifdef MEM_ADDR_CHECK_EN
          chk("err", 32'(err), 32'(mon_e.er));
`endif
        end
        wait_seen = 0;
      end
    end
  end

  // Issue one access; the model decides the outcome from the behavioural rules.
  task automatic issue(bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] d, int hold, bit early);
    exp_t x;
    int   idx;
    bit   ok;
    int   n;
    @(posedge clk); #1;
    W = w; R = r; addr = a; wdata = d;
    ok  = 1'b1;
    idx = int'(a) % DEP;
`ifdef MEM_ADDR_CHECK_EN
    ok  = (int'(a) < DEP);
    idx = int'(a);
`endif
    if (ok) begin
      if (w) mdl[idx] = d;
      else   last_rd  = mdl[idx];
    end
    x.rd  = last_rd;
    x.er  = !ok;
    x.due = cyc + 1 + WC;
    sb.push_back(x);
    if (early) begin
      @(posedge clk); #1;
      W = 1'b0; R = 1'b0; addr = AW'($urandom); wdata = $urandom;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < 40);
    if (!Done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no Done after %0d cycles expected Done", n);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    W = 1'b0; R = 1'b0;
  endtask

  task automatic reset_mid_wait();
    @(posedge clk); #1;
    W = 1'b1; addr = AW'(9); wdata = 32'hAAAA;
    @(posedge clk); #1;
    chk("wait_before_reset", 32'(Wait), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_wait", 32'(Wait), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    last_rd = '0;
    W = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit            rw_w, rw_r;
    logic [AW-1:0] ra;
    #1 rst_n = 1'b0;
    #2;
    chk("init_wait", 32'(Wait), 32'd0);
    chk("init_done", 32'(Done), 32'd0);
    chk("init_rdata", rdata, 32'd0);
`ifdef MEM_ADDR_CHECK_EN
    chk("init_err", 32'(err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < DEP; a++) issue(1'b1, 1'b0, AW'(a), $urandom, 0, 1'b0);

    issue(1'b1, 1'b0, AW'(5), 32'hDEADBEEF, 0, 1'b0);
    issue(1'b0, 1'b1, AW'(5), 32'h0, 6, 1'b0);
    issue(1'b0, 1'b1, AW'(5), 32'h0, 0, 1'b0);
    issue(1'b1, 1'b1, AW'(7), 32'h1234, 0, 1'b0);
    issue(1'b0, 1'b1, AW'(7), 32'h0, 0, 1'b0);
    reset_mid_wait();
    issue(1'b0, 1'b1, AW'(9), 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, AW'(20), 32'h5A5A5A5A, 0, 1'b1);
    issue(1'b0, 1'b1, AW'(20), 32'h0, 0, 1'b1);
    issue(1'b1, 1'b0, AW'(210), 32'hFFFF, 0, 1'b0);
    issue(1'b0, 1'b1, AW'(10), 32'h0, 0, 1'b0);
    issue(1'b0, 1'b1, AW'(199), 32'h0, 0, 1'b0);
    issue(1'b0, 1'b1, AW'(255), 32'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rw_w = 1'($urandom);
      rw_r = 1'($urandom);
      if (!rw_w && !rw_r) rw_r = 1'b1;
      ra = AW'($urandom);
      issue(rw_w, rw_r, ra, $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
